// File: rtl/branch_predictor_if.sv
// Pipeline-side bundle for the branch predictor: Fetch lookup, Execute resolution,
// redirect request and performance counters.
interface branch_predictor_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      PCF;
  logic             PredTakenF;
  logic [31:0]      PredTargetF;
  logic [31:0]      PCE;
  logic             BranchE;
  logic             JumpE;
  logic             PCSrcE;
  logic [31:0]      PCTargetE;
  logic             PredTakenE;
  logic [31:0]      PredTargetE;
  logic             StallE;
  logic             FlushE;
  logic             MispredictE;
  logic [31:0]      CorrectPCE;
  logic [CNT_W-1:0] BranchCount;
  logic [CNT_W-1:0] MispredCount;

  modport master (
    output PCF, PCE, BranchE, JumpE, PCSrcE, PCTargetE,
           PredTakenE, PredTargetE, StallE, FlushE,
    input  PredTakenF, PredTargetF, MispredictE, CorrectPCE,
           BranchCount, MispredCount
  );

  modport slave (
    input  PCF, PCE, BranchE, JumpE, PCSrcE, PCTargetE,
           PredTakenE, PredTargetE, StallE, FlushE,
    output PredTakenF, PredTargetF, MispredictE, CorrectPCE,
           BranchCount, MispredCount
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: predicts at Fetch, verifies and trains at
// Execute, and raises a redirect with the corrected PC on a misprediction.
module branch_predictor #(
  parameter int INDEX_BITS = 4,
  parameter int CNT_W      = 16
) (
  input logic              CLK,
  input logic              RST,
  branch_predictor_if.slave bp
);
  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = 30 - INDEX_BITS;

  logic             valid_q  [ENTRIES];
  logic             valid_d  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [31:0]      target_d [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];
  logic [1:0]       ctr_d    [ENTRIES];
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic [INDEX_BITS-1:0] idx_f, idx_e;
  logic [TAG_W-1:0]      tag_f, tag_e;
  logic                  hit_f, hit_e;
  logic                  ctrl_e, active_e, alias_e, mispredict;
  logic                  unused_pc_bits;

  assign idx_f = bp.PCF[INDEX_BITS+1:2];
  assign tag_f = bp.PCF[31:INDEX_BITS+2];
  assign idx_e = bp.PCE[INDEX_BITS+1:2];
  assign tag_e = bp.PCE[31:INDEX_BITS+2];
  assign unused_pc_bits = ^bp.PCF[1:0];

  // Lookup reads registered state only, so a same-cycle update is seen next cycle.
  assign hit_f          = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign hit_e          = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
  assign bp.PredTakenF  = hit_f & ctr_q[idx_f][1];
  assign bp.PredTargetF = hit_f ? target_q[idx_f] : 32'd0;

  assign ctrl_e   = bp.BranchE | bp.JumpE;
  assign active_e = ctrl_e & ~bp.StallE & ~bp.FlushE;
  assign alias_e  = ~ctrl_e & bp.PredTakenE & ~bp.StallE & ~bp.FlushE;

  always_comb begin
    mispredict = 1'b0;
    if (!bp.FlushE) begin
      if (bp.PredTakenE)
        mispredict = ~bp.PCSrcE | (bp.PredTargetE != bp.PCTargetE);
      else
        mispredict = bp.PCSrcE;
    end
  end

  assign bp.MispredictE  = mispredict;
  assign bp.CorrectPCE   = bp.PCSrcE ? bp.PCTargetE : (bp.PCE + 32'd4);
  assign bp.BranchCount  = branch_cnt_q;
  assign bp.MispredCount = mispred_cnt_q;

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (active_e) begin
      if (hit_e) begin
        if (bp.PCSrcE)
          target_d[idx_e] = bp.PCTargetE;
        if (bp.JumpE)
          ctr_d[idx_e] = 2'b11;
        else if (bp.PCSrcE)
          ctr_d[idx_e] = (ctr_q[idx_e] == 2'b11) ? 2'b11 : ctr_q[idx_e] + 2'd1;
        else
          ctr_d[idx_e] = (ctr_q[idx_e] == 2'b00) ? 2'b00 : ctr_q[idx_e] - 2'd1;
      end else if (bp.PCSrcE) begin
        valid_d[idx_e]  = 1'b1;
        tag_d[idx_e]    = tag_e;
        target_d[idx_e] = bp.PCTargetE;
        ctr_d[idx_e]    = bp.JumpE ? 2'b11 : 2'b10;
      end
    end else if (alias_e) begin
      // A non-control instruction predicted taken weakens whatever entry it aliased.
      ctr_d[idx_e] = (ctr_q[idx_e] == 2'b00) ? 2'b00 : ctr_q[idx_e] - 2'd1;
    end
  end

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (active_e || (alias_e && mispredict)) begin
      if (active_e && (branch_cnt_q != {CNT_W{1'b1}}))
        branch_cnt_d = branch_cnt_q + 1'b1;
      if (mispredict && (mispred_cnt_q != {CNT_W{1'b1}}))
        mispred_cnt_d = mispred_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 32'd0;
        ctr_q[i]    <= 2'b01;
      end
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      valid_q       <= valid_d;
      tag_q         <= tag_d;
      target_q      <= target_d;
      ctr_q         <= ctr_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor and redirect controller for the 5-stage RV32I pipeline.
- Predicts direction and target for the Fetch-stage PC from a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Checks each prediction against the Execute-stage branch resolution (PCSrcE, PCTargetE from the branch-condition logic), trains the tables and raises MispredictE with the correct PC for the hazard unit.
- Keeps saturating performance counters.

Parameters:
- INDEX_BITS, 4: log2 of BTB entry count (16 entries); index = PC[INDEX_BITS+1:2].
- CNT_W, 16: width of the performance counters.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-low.
- PCF  in  32  Fetch-stage PC.
- PredTakenF  out  1  prediction: redirect fetch to PredTargetF.
- PredTargetF  out  32  predicted target (valid only when PredTakenF=1).
- PCE  in  32  Execute-stage PC.
- BranchE  in  1  Execute instruction is a conditional branch.
- JumpE  in  1  Execute instruction is jal/jalr.
- PCSrcE  in  1  resolved taken.
- PCTargetE  in  32  resolved target.
- PredTakenE  in  1  prediction made for the Execute instruction, piped from F by the pipeline registers.
- PredTargetE  in  32  target predicted for the Execute instruction, piped.
- StallE  in  1  Execute held; no training or counting.
- FlushE  in  1  Execute holds a bubble; no training, no mispredict.
- MispredictE  out  1  redirect required; the hazard unit flushes D/E.
- CorrectPCE  out  32  PC to fetch when MispredictE=1.
- BranchCount  out  CNT_W  resolved control-flow instructions, saturating.
- MispredCount  out  CNT_W  mispredictions, saturating.

Behaviour:
- Entry state: valid (1), tag = PC[31:INDEX_BITS+2], target (32), ctr (2).
- Reset (RST=0, async):
  - all valid=0, all ctr=2'b01, both counters=0.
  - Outputs: PredTakenF=0, PredTargetF=0, MispredictE=0, CorrectPCE=PCE+4.
- Lookup, combinational from registered state:
  - hit = valid[idxF] & tag match.
  - PredTakenF = hit & ctr[idxF][1].
  - PredTargetF = target[idxF] when hit, else 0.
- Active = (BranchE | JumpE) & ~StallE & ~FlushE.
- Mispredict, combinational, gated by ~FlushE:
  - PredTakenE=1: MispredictE = ~PCSrcE | (PredTargetE != PCTargetE).
  - PredTakenE=0: MispredictE = PCSrcE.
  - A non-control instruction with PredTakenE=1 (alias) mispredicts.
  - CorrectPCE = PCSrcE ? PCTargetE : PCE+4; PC+4 wraps modulo 2^32.
- Training, on the clock edge when Active:
  - Entry hit (valid & tag match): target <= PCTargetE if PCSrcE.
    - JumpE: ctr <= 11.
    - Branch taken: ctr increments, saturating at 11.
    - Branch not taken: ctr decrements, saturating at 00.
  - Entry miss, taken: allocate; valid=1, tag, target=PCTargetE, ctr = JumpE ? 11 : 10.
  - Entry miss, not taken: no allocation.
  - Alias with no control instruction (BranchE=JumpE=0, PredTakenE=1, ~StallE, ~FlushE): ctr[idxE] decrements, saturating.
- Counters, when Active or on an alias mispredict:
  - BranchCount += Active.
  - MispredCount += MispredictE.
  - Both saturate at all-ones, no wrap.
- Same-cycle lookup and update of one index: lookup returns the pre-update value; the write is visible the next cycle.
- StallE=1 holds all state; MispredictE still reflects the current inputs.
- Reset mid-operation clears tables immediately; the next PCF lookup misses.

Test Plan:
- Reset, PCF=0x100 -> PredTakenF=0; counters 0; MispredictE=0 with all E inputs 0.
- Cold branch at PCE=0x100, BranchE=1, PCSrcE=1, PCTargetE=0x80, PredTakenE=0:
  - MispredictE=1, CorrectPCE=0x80.
  - Next cycle PCF=0x100 -> PredTakenF=1, PredTargetF=0x80; MispredCount=1, BranchCount=1.
- Same entry (ctr=10), resolved not-taken twice with PredTakenE as predicted:
  - First: MispredictE=1, CorrectPCE=0x104, ctr 10->01.
  - Second: no mispredict, ctr 01->00.
  - PCF=0x100 -> PredTakenF=0.
- JumpE at 0x200 to 0x400, predicted taken with PredTargetE=0x300 -> MispredictE=1, CorrectPCE=0x400; entry target becomes 0x400, ctr=11.
- FlushE=1 or StallE=1 with a taken branch -> MispredictE=0 when flushed; no table or counter change in either case.
- Force MispredCount to 0xFFFF, then mispredict -> stays 0xFFFF; PCE=0xFFFFFFFC not-taken mispredict -> CorrectPCE=0x0.
